// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter and sequencer for the write side of an asynchronous
// FIFO. NUM_REQ requesters in the write-clock domain share one FIFO write
// port. Each grant covers a burst of up to MAX_BURST beats. Each beat is
// gated on Full. A flush request clears the FIFO for CLEAR_CYCLES cycles,
// and the clear never overlaps a write.
//
// Optional feature: define FIFO_ARB_STALL_TIMEOUT_EN to add a stall counter.
// The counter releases an owner that has been blocked by Full for
// STALL_LIMIT consecutive cycles.
//
// Ports:
//   Clk          write-domain clock (FIFO WClk)
//   Rst_n        synchronous active-low reset
//   Req_in       per-requester write request; data is valid while high
//   ReqData_in   packed requester data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Flush_in     single-cycle pulse requesting a FIFO clear
//   Full_in      FIFO full flag
//   Grant_out    registered one-hot current owner
//   Ack_out      beat accepted this cycle (one-hot or zero)
//   WriteEn_out  FIFO write enable
//   Data_out     FIFO write data
//   Clear_out    registered FIFO clear
//   Busy_out     arbiter not idle
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int STALL_LIMIT  = 8
) (
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic [NUM_REQ-1:0]               Req_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    ReqData_in,
    input  logic                             Flush_in,
    input  logic                             Full_in,
    output logic [NUM_REQ-1:0]               Grant_out,
    output logic [NUM_REQ-1:0]               Ack_out,
    output logic                             WriteEn_out,
    output logic [DATA_WIDTH-1:0]            Data_out,
    output logic                             Clear_out,
    output logic                             Busy_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..15");
    end
    if (CLEAR_CYCLES < 1) begin : g_bad_clear_cycles
        $error("CLEAR_CYCLES must be at least 1");
    end
    if (STALL_LIMIT < 1) begin : g_bad_stall_limit
        $error("STALL_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CLR_W-1:0]   clear_cnt_q, clear_cnt_d;

`ifdef FIFO_ARB_STALL_TIMEOUT_EN
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
`endif

    logic [PTR_W-1:0]   owner;
    logic               owner_req;
    logic               beat;
    logic [PTR_W-1:0]   winner;
    logic               found;
    int                 rr_idx;

    // Index of the current owner, decoded from the one-hot grant.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Grant_out[i]) owner = PTR_W'(i);
        end
    end

    // A flush in a burst cycle suppresses that cycle's beat, so a clear
    // never follows a write in the same cycle.
    assign owner_req   = |(Req_in & Grant_out);
    assign beat        = (state_q == S_BURST) && owner_req && !Full_in && !Flush_in;
    assign WriteEn_out = beat;
    assign Ack_out     = Grant_out & {NUM_REQ{beat}};
    assign Data_out    = beat ? ReqData_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign Busy_out    = (state_q != S_IDLE);

    // Round-robin pick: first requester at or after rr_ptr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && Req_in[rr_idx]) begin
                found  = 1'b1;
                winner = PTR_W'(rr_idx);
            end
        end
    end

    // NOTE: every combinationally written signal gets a default first, so
    // no branch can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_d     = Grant_out;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        clear_cnt_d = clear_cnt_q;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                beat_cnt_d  = '0;
                clear_cnt_d = '0;
                if (Flush_in) begin
                    state_d = S_CLEAR;
                end else if (found) begin
                    grant_d  = NUM_REQ'(1) << winner;
                    rr_ptr_d = PTR_W'((int'(winner) + 1) % NUM_REQ);
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (Flush_in) begin
                    grant_d     = '0;
                    beat_cnt_d  = '0;
                    clear_cnt_d = '0;
                    state_d     = S_CLEAR;
                end else if (!owner_req) begin
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (beat) begin
                    if (beat_cnt_q == BC_W'(MAX_BURST - 1)) begin
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else begin
                    // Owner is requesting but Full blocks it. The grant and
                    // the beat count are held.
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
                    if (stall_cnt_q == SC_W'(STALL_LIMIT - 1)) begin
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_CLEAR: begin
                grant_d = '0;
                if (clear_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    clear_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the reset is sampled on the clock edge, so it sits inside the
    // clocked block. All state uses non-blocking assignments, so every
    // register sees the pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            Grant_out   <= '0;
            Clear_out   <= 1'b0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            clear_cnt_q <= '0;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            Grant_out   <= grant_d;
            // Clear_out is registered and high exactly while in CLEAR.
            Clear_out   <= (state_d == S_CLEAR);
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            clear_cnt_q <= clear_cnt_d;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. A behavioural model tracks the
// owner, the round-robin pointer, the beats taken and the remaining clear
// cycles as plain integers. Every cycle, the model's expected outputs are
// compared with the DUT. Directed scenarios come first, then randomized
// traffic.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CC = 2;
    localparam int SL = 8;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic [N-1:0]      Req_in;
    logic [N*DW-1:0]   ReqData_in;
    logic              Flush_in;
    logic              Full_in;
    logic [N-1:0]      Grant_out;
    logic [N-1:0]      Ack_out;
    logic              WriteEn_out;
    logic [DW-1:0]     Data_out;
    logic              Clear_out;
    logic              Busy_out;

    always #5 Clk = ~Clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB),
        .CLEAR_CYCLES(CC), .STALL_LIMIT(SL)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req_in(Req_in), .ReqData_in(ReqData_in),
        .Flush_in(Flush_in), .Full_in(Full_in), .Grant_out(Grant_out),
        .Ack_out(Ack_out), .WriteEn_out(WriteEn_out), .Data_out(Data_out),
        .Clear_out(Clear_out), .Busy_out(Busy_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: owner is -1 when nobody holds the port.
    int m_owner, m_ptr, m_beats, m_clear_left, m_stall;

    // Observation logs used by the directed scenarios.
    int grant_log[$];
    int run_log[$];
    int run_len;
    int we_seen;
    logic [N-1:0] last_grant;

    function automatic logic [DW-1:0] req_data(input int i);
        logic [N*DW-1:0] v;
        v = ReqData_in;
        return v[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_clear_left = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] g_exp;
        logic         beat_exp;
        g_exp    = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        beat_exp = (m_owner >= 0) && Req_in[m_owner] && !Full_in && !Flush_in;
        check("grant",   32'(Grant_out),   32'(g_exp));
        check("clear",   32'(Clear_out),   32'(m_clear_left > 0));
        check("busy",    32'(Busy_out),    32'((m_owner >= 0) || (m_clear_left > 0)));
        check("wr_en",   32'(WriteEn_out), 32'(beat_exp));
        check("ack",     32'(Ack_out),     32'(beat_exp ? g_exp : '0));
        check("data",    32'(Data_out),    32'(beat_exp ? req_data(m_owner) : '0));
        check("we_and_clear", 32'(WriteEn_out & Clear_out), 32'(0));
    endtask

    task automatic model_step();
        if (!Rst_n) begin
            model_reset();
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_owner < 0) begin
            if (Flush_in) begin
                m_clear_left = CC;
            end else if (Req_in != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && Req_in[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_ptr   = (m_owner + 1) % N;
                m_beats = 0;
                m_stall = 0;
            end
        end else if (Flush_in) begin
            m_owner = -1;
            m_clear_left = CC;
        end else if (!Req_in[m_owner]) begin
            m_owner = -1;
        end else if (!Full_in) begin
            m_beats++;
            m_stall = 0;
            if (m_beats == MB) m_owner = -1;
        end else begin
            m_stall++;
            if (TIMEOUT_EN && m_stall == SL) m_owner = -1;
        end
    endtask

    task automatic observe();
        if (Grant_out != '0 && last_grant == '0) begin
            for (int k = 0; k < N; k++) if (Grant_out[k]) grant_log.push_back(k);
        end
        last_grant = Grant_out;
        if (WriteEn_out) begin
            run_len++;
            we_seen++;
        end else if (run_len > 0) begin
            run_log.push_back(run_len);
            run_len = 0;
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        run_log.delete();
        run_len = 0;
        we_seen = 0;
        last_grant = Grant_out;
    endtask

    // One clock cycle: drive, settle, compare, advance model, cross the edge.
    task automatic tick(input logic [N-1:0] req, input logic full,
                        input logic flush, input logic rst_n);
        Req_in   = req;
        Full_in  = full;
        Flush_in = flush;
        Rst_n    = rst_n;
        for (int k = 0; k < N; k++) ReqData_in[k*DW +: DW] = DW'($urandom);
        #1;
        check_outputs();
        observe();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        tick('0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        Rst_n = 1'b0; Req_in = '0; Full_in = 1'b0; Flush_in = 1'b0; ReqData_in = '0;
        @(posedge Clk);
        #1;
        model_reset();
        last_grant = '0;

        // Reset held with all requesters active.
        tick(4'b1111, 1'b0, 1'b0, 1'b0);
        tick(4'b1111, 1'b0, 1'b0, 1'b0);

        // Fairness: every requester busy, FIFO never full.
        clear_logs();
        for (int c = 0; c < 25; c++) tick(4'b1111, 1'b0, 1'b0, 1'b1);
        check("fair_grants", 32'(grant_log.size() >= 5), 32'(1));
        check("fair_runs",   32'(run_log.size() >= 4),   32'(1));
        for (int k = 0; k < 5; k++)
            if (k < grant_log.size()) check("fair_order", 32'(grant_log[k]), 32'(exp_order[k]));
        for (int k = 0; k < 4; k++)
            if (k < run_log.size()) check("fair_burst_len", 32'(run_log[k]), 32'(MB));

        // Full stall: requester 1 blocked after two beats.
        do_reset();
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick(4'b0010, 1'b1, 1'b0, 1'b1);
            check("stall_grant_held", 32'(Grant_out), 32'(4'b0010));
        end
        clear_logs();
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        check("stall_release", 32'(Grant_out), 32'(0));
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        check("stall_tail_beats", 32'(we_seen), 32'(2));

        // Early drop: requester 2 stops after one beat, requester 3 is next.
        do_reset();
        tick(4'b1100, 1'b0, 1'b0, 1'b1);
        check("drop_grant2", 32'(Grant_out), 32'(4'b0100));
        tick(4'b1100, 1'b0, 1'b0, 1'b1);
        tick(4'b1000, 1'b0, 1'b0, 1'b1);
        check("drop_released", 32'(Grant_out), 32'(0));
        tick(4'b1000, 1'b0, 1'b0, 1'b1);
        check("drop_next_grant3", 32'(Grant_out), 32'(4'b1000));

        // Flush on requester 0's second beat cycle.
        do_reset();
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(4'b0001, 1'b0, 1'b1, 1'b1);
        check("flush_clear_1", 32'(Clear_out), 32'(1));
        tick(4'b0011, 1'b0, 1'b0, 1'b1);
        check("flush_clear_2", 32'(Clear_out), 32'(1));
        tick(4'b0011, 1'b0, 1'b0, 1'b1);
        check("flush_clear_done", 32'(Clear_out), 32'(0));
        tick(4'b0011, 1'b0, 1'b0, 1'b1);
        check("flush_next_grant1", 32'(Grant_out), 32'(4'b0010));

        // Persistent Full with requesters 0 and 1.
        do_reset();
        clear_logs();
        for (int c = 0; c < 30; c++) tick(4'b0011, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
        check("timeout_rotates", 32'(grant_log.size() >= 2), 32'(1));
        if (grant_log.size() >= 2) check("timeout_second_owner", 32'(grant_log[1]), 32'(1));
`else
        check("hold_single_grant", 32'(grant_log.size()), 32'(1));
        check("hold_owner0", 32'(Grant_out), 32'(4'b0001));
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter and sequencer for the asynFifo write side.
- Shares one FIFO write port (WriteEn/Data/Full/Clear) among NUM_REQ requesters in the write-clock domain.
- Grants bounded bursts and gates each beat on Full.
- Sequences FIFO clear requests so a clear never overlaps a write.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..15).
- CLEAR_CYCLES, 2, cycles Clear_out is held high per flush (>=1).
- STALL_LIMIT, 8, Full-stall cycles before forced release (optional feature only).

Ports:
- Clk  in  1  write-domain clock (FIFO WClk).
- Rst_n  in  1  reset, synchronous, active-low.
- Req_in  in  NUM_REQ  per-requester write request; data valid while high.
- ReqData_in  in  NUM_REQ*DATA_WIDTH  packed requester data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- Flush_in  in  1  single-cycle pulse requesting a FIFO clear.
- Full_in  in  1  FIFO Full_out.
- Grant_out  out  NUM_REQ  registered one-hot current owner.
- Ack_out  out  NUM_REQ  beat accepted this cycle; requester advances its data.
- WriteEn_out  out  1  to FIFO WriteEn_in.
- Data_out  out  DATA_WIDTH  to FIFO Data_in.
- Clear_out  out  1  registered, to FIFO Clear_in.
- Busy_out  out  1  state != IDLE.

Behaviour:
- Reset (Rst_n low at a Clk edge): state IDLE, Grant_out=0, Clear_out=0, RR pointer=0, beat count=0. Combinational outputs are then WriteEn_out=0, Ack_out=0, Data_out=0, Busy_out=0. Reset mid-burst drops the grant at that edge; no partial-beat write occurs.
- States: IDLE, BURST, CLEAR.
- IDLE:
  - Flush_in=1 -> CLEAR. Flush has priority over requests.
  - Else if any Req_in, pick the first requester at or after the RR pointer (wrapping modulo NUM_REQ). Set Grant_out one-hot next edge, beat count=0, RR pointer=winner+1 mod NUM_REQ -> BURST.
- BURST (owner g):
  - Beat condition: Req_in[g] && !Full_in.
  - When the beat condition holds, WriteEn_out=1, Ack_out[g]=1, Data_out=ReqData_in[g] in the same cycle (combinational), and beat count increments.
  - Full_in=1 with Req_in[g]=1: stall. No write, count held, grant held.
  - Burst ends when a beat completes with count reaching MAX_BURST, or when Req_in[g]=0 (no beat that cycle). On end: Grant_out=0, -> IDLE.
  - Flush_in=1: no beat that cycle. Grant dropped, -> CLEAR.
- Latency: Req rising in IDLE -> Grant_out at the next edge -> first beat in that cycle if not Full. Minimum one idle cycle between bursts.
- CLEAR: Clear_out=1 for exactly CLEAR_CYCLES cycles, Grant_out=0, WriteEn_out=0. Flush_in is ignored in CLEAR. Then -> IDLE with Clear_out=0. RR pointer is preserved.
- Outside BURST: WriteEn_out=0, Ack_out=0, Data_out=0.
- Invariants: WriteEn_out and Clear_out are never both 1. Ack_out is one-hot or zero and equals Grant_out & {NUM_REQ{WriteEn_out}}.

Optional Feature:
- Macro: FIFO_ARB_STALL_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles with Req_in[g] && Full_in.
  - Reaching STALL_LIMIT ends the burst (-> IDLE, grant dropped), letting other requesters rotate in.
  - The counter clears on any beat, on burst end and on reset.
- Undefined: no counter; a stalled owner keeps its grant indefinitely.

Test Plan:
- Reset: Rst_n=0 for 2 cycles with Req_in=4'b1111 -> Grant_out=0, WriteEn_out=0, Clear_out=0 throughout. After release, first grant is requester 0.
- Fairness: Req_in=4'b1111 held, Full_in=0, MAX_BURST=4 -> grants in order 0,1,2,3,0. Each burst is exactly 4 consecutive WriteEn_out cycles followed by 1 idle cycle. Data_out matches the owner's ReqData_in on each beat.
- Full stall: owner 1 mid-burst after 2 beats, Full_in=1 for 5 cycles -> no WriteEn_out, Ack_out=0, Grant_out=4'b0010 held. After Full_in drops, exactly 2 more beats, then release.
- Early drop: requester 2 deasserts Req_in after 1 beat -> Grant_out=0 next edge. Next grant goes to requester 3 if requesting.
- Flush mid-burst: Flush_in pulse during requester 0's 2nd beat cycle -> no write that cycle. Clear_out high for exactly 2 cycles, then IDLE. The next grant follows the preserved RR pointer (requester 1).
- With FIFO_ARB_STALL_TIMEOUT_EN: Full_in=1 held, Req_in=4'b0011 -> owner 0 released after 8 stall cycles, then requester 1 granted. Without the macro, owner 0 holds the grant for 20+ cycles.
